uart_tx_arbiter: RTL

Shares the UART PHY transmit path between `NUM_REQ` byte-stream requesters. Round-robin arbitration; the winner streams bytes into the PHY write FIFO (`wr_fifo_enable`/`wr_fifo_data`). Flow control comes from an in-flight credit counter driven by the PHY `tx_done` pulse, because the PHY exposes no FIFO-full flag. Sits between the register/bus front end and `uart_phy`, in the PHY `clk1` domain.

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART PHY transmit FIFO between NUM_REQ byte-stream requesters.
// Round-robin arbitration with credit-based flow control driven by the PHY tx_done pulse.
// Optional feature macro: UART_ARB_PKT_LOCK_EN
//   defined   - grant held for a whole packet, released by a transfer with req_last
//   undefined - every transfer releases the grant (byte-level interleaving, req_last ignored)
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned UART_FIFO_WIDTH = 8,
    parameter int unsigned UART_FIFO_DEPTH = 8,
    parameter int unsigned CNT_W           = 4
) (
    input  logic                               clk1,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*UART_FIFO_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               tx_done,
    output logic                               wr_fifo_enable,
    output logic [UART_FIFO_WIDTH-1:0]         wr_fifo_data,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               busy,
    output logic [CNT_W-1:0]                   inflight_cnt
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } state_e;

    state_e                     r_state;
    state_e                     w_state_next;
    logic [NUM_REQ-1:0]         r_grant;
    logic [NUM_REQ-1:0]         w_grant_next;
    logic [PTR_W-1:0]           r_rr_ptr;
    logic [PTR_W-1:0]           w_rr_ptr_next;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_next;
    logic                       r_wr_en;
    logic                       w_wr_en_next;
    logic [UART_FIFO_WIDTH-1:0] r_wr_data;
    logic [UART_FIFO_WIDTH-1:0] w_wr_data_next;

    logic [NUM_REQ-1:0]         w_pick_oh;
    logic [PTR_W-1:0]           w_gidx;
    logic [UART_FIFO_WIDTH-1:0] w_xfer_data;
    logic                       w_credit_ok;
    logic                       w_xfer;
    logic                       w_release;
    logic                       w_done_eff;

    // Round-robin pick: first valid index at or above rr_ptr, else the lowest valid index.
    always_comb begin : pick
        int   v_lo;
        int   v_hi;
        int   v_sel;
        logic v_lo_found;
        logic v_hi_found;
        v_lo       = 0;
        v_hi       = 0;
        v_lo_found = 1'b0;
        v_hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                v_lo       = i;
                v_lo_found = 1'b1;
                if (i >= int'(r_rr_ptr)) begin
                    v_hi       = i;
                    v_hi_found = 1'b1;
                end
            end
        end
        v_sel     = v_hi_found ? v_hi : v_lo;
        w_pick_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pick_oh[i] = v_lo_found && (i == v_sel);
        end
    end

    // Decode the owner index and select its byte.
    always_comb begin
        w_gidx      = '0;
        w_xfer_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx      = PTR_W'(i);
                w_xfer_data = req_data[i*UART_FIFO_WIDTH +: UART_FIFO_WIDTH];
            end
        end
    end

    // No FIFO-full flag from the PHY, so readiness is gated purely on outstanding credits.
    assign w_credit_ok = (r_cnt < CNT_W'(UART_FIFO_DEPTH));
    assign req_ready   = ((r_state == StLock) && w_credit_ok) ? r_grant : '0;
    assign w_xfer      = |(req_valid & req_ready);

`ifdef UART_ARB_PKT_LOCK_EN
    assign w_release = |(req_valid & req_ready & req_last);
`else
    logic w_unused_last;
    assign w_unused_last = ^req_last;
    assign w_release     = w_xfer;
`endif

    // A tx_done with nothing in flight is spurious and must not underflow the counter.
    assign w_done_eff = tx_done && (r_cnt != '0);

    // Credit counter next state.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_xfer && !w_done_eff) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end else if (!w_xfer && w_done_eff) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
    end

    // Arbitration FSM next state, grant and FIFO write staging.
    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_rr_ptr_next  = r_rr_ptr;
        w_wr_en_next   = w_xfer;
        w_wr_data_next = w_xfer ? w_xfer_data : r_wr_data;
        unique case (r_state)
            StIdle: begin
                if (|req_valid) begin
                    w_grant_next = w_pick_oh;
                    w_state_next = StLock;
                end
            end
            StLock: begin
                if (w_release) begin
                    w_grant_next  = '0;
                    w_rr_ptr_next = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
                    w_state_next  = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_cnt     <= w_cnt_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    assign grant          = r_grant;
    assign inflight_cnt   = r_cnt;
    assign wr_fifo_enable = r_wr_en;
    assign wr_fifo_data   = r_wr_data;
    assign busy           = (|r_grant) || (r_cnt != '0);

endmodule
